// File: rtl/icache_fetch_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_buf_if
// Description : Fetch-stage front end to the instruction cache. Holds one
//               icache line in a local buffer so that sequential fetches
//               within the same line are served without an icache access.
//               Misses are forwarded to the icache; the returned line fills
//               the buffer and the requested word is returned one cycle later.
//
// Ports:
//   clk_i, rstn_i            clock / asynchronous active-low reset
//   req_*_i, req_ready_o     fetch request (vaddr, kill, buffer flush,
//                            icache invalidate)
//   icache_req_*             request channel toward the icache
//   icache_invalidate_o      forwarded icache invalidate
//   icache_resp_*, tlb_xcpt_i  icache response / instruction page fault
//   resp_*_o                 registered fetch response (single-cycle valid)
//   buffer_miss_o            one-cycle pulse per accepted line-buffer miss
//
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_buf_if #(
    parameter int LINE_BITS  = 128,
    parameter int INSTR_BITS = 32,
    parameter int VADDR_BITS = 40
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    input  logic [VADDR_BITS-1:0] req_vaddr_i,
    input  logic                  req_kill_i,
    input  logic                  req_flush_buf_i,
    input  logic                  req_inval_icache_i,
    output logic                  req_ready_o,
    output logic                  icache_req_valid_o,
    input  logic                  icache_req_ready_i,
    output logic [VADDR_BITS-1:0] icache_req_vaddr_o,
    output logic                  icache_req_kill_o,
    output logic                  icache_invalidate_o,
    input  logic                  icache_resp_valid_i,
    input  logic [LINE_BITS-1:0]  icache_resp_data_i,
    input  logic                  tlb_xcpt_i,
    output logic                  resp_valid_o,
    output logic [INSTR_BITS-1:0] resp_data_o,
    output logic [VADDR_BITS-1:0] resp_vaddr_o,
    output logic                  resp_page_fault_o,
    output logic                  buffer_miss_o
);

    localparam int OFS   = $clog2(LINE_BITS / 8);
    localparam int WOFS  = $clog2(INSTR_BITS / 8);
    localparam int IDX_W = OFS - WOFS;
    localparam int NW    = LINE_BITS / INSTR_BITS;
    localparam int TAG_W = VADDR_BITS - OFS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_DRAIN     = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_buf_valid;
    logic [TAG_W-1:0]        r_buf_tag;
    logic [LINE_BITS-1:0]    r_buf_data;
    logic [VADDR_BITS-1:0]   r_vaddr;

    logic                    r_resp_valid;
    logic [INSTR_BITS-1:0]   r_resp_data;
    logic [VADDR_BITS-1:0]   r_resp_vaddr;
    logic                    r_resp_pf;

    logic                    w_req_qual;
    logic                    w_tag_hit;
    logic                    w_hit;
    logic                    w_miss_accept;
    logic                    w_kill_out;
    logic                    w_fill;
    logic                    w_deliver;
    logic                    w_deliver_pf;
    logic                    w_buf_clear;

    // Word index within a line; word 0 sits at the line LSBs.
    function automatic logic [INSTR_BITS-1:0] f_sel_word(
        input logic [LINE_BITS-1:0] line,
        input logic [IDX_W-1:0]     idx
    );
        f_sel_word = '0;
        for (int k = 0; k < NW; k++) begin
            if (idx == k[IDX_W-1:0]) begin
                f_sel_word = line[k*INSTR_BITS +: INSTR_BITS];
            end
        end
    endfunction

    assign w_req_qual  = req_valid_i & ~req_kill_i & ~req_flush_buf_i;
    assign w_tag_hit   = r_buf_valid & (r_buf_tag == req_vaddr_i[VADDR_BITS-1:OFS]);
    assign w_buf_clear = req_flush_buf_i | req_inval_icache_i;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_hit         = 1'b0;
        w_miss_accept = 1'b0;
        w_kill_out    = 1'b0;
        w_fill        = 1'b0;
        w_deliver     = 1'b0;
        w_deliver_pf  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_qual) begin
                    if (w_tag_hit) begin
                        w_hit = 1'b1;
                    end else if (icache_req_ready_i) begin
                        w_miss_accept = 1'b1;
                        w_state_nxt   = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                // A page fault wins over a simultaneous line response.
                if (tlb_xcpt_i) begin
                    w_deliver_pf = ~req_kill_i;
                    w_state_nxt  = S_IDLE;
                end else if (icache_resp_valid_i) begin
                    // Fill even when killed: the line itself is still good.
                    w_fill      = 1'b1;
                    w_deliver   = ~req_kill_i;
                    w_state_nxt = S_IDLE;
                end else if (req_kill_i) begin
                    w_kill_out  = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (icache_resp_valid_i | tlb_xcpt_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Line buffer and miss address
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_vaddr     <= '0;
        end else begin
            // Flush / invalidate override a fill landing in the same cycle.
            if (w_buf_clear) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill) begin
                r_buf_valid <= 1'b1;
            end
            if (w_fill) begin
                r_buf_data <= icache_resp_data_i;
                r_buf_tag  <= r_vaddr[VADDR_BITS-1:OFS];
            end
            if (w_miss_accept) begin
                r_vaddr <= req_vaddr_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered response; payload holds while no response is produced
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_vaddr <= '0;
            r_resp_pf    <= 1'b0;
        end else begin
            r_resp_valid <= w_hit | w_deliver | w_deliver_pf;
            if (w_hit) begin
                r_resp_data  <= f_sel_word(r_buf_data, req_vaddr_i[OFS-1:WOFS]);
                r_resp_vaddr <= req_vaddr_i;
                r_resp_pf    <= 1'b0;
            end else if (w_deliver) begin
                r_resp_data  <= f_sel_word(icache_resp_data_i, r_vaddr[OFS-1:WOFS]);
                r_resp_vaddr <= r_vaddr;
                r_resp_pf    <= 1'b0;
            end else if (w_deliver_pf) begin
                r_resp_data  <= '0;
                r_resp_vaddr <= r_vaddr;
                r_resp_pf    <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The miss request is only raised when the icache can take
    // it, so valid mirrors ready; reset masks the combinational paths.
    // ------------------------------------------------------------------
    assign req_ready_o         = (r_state == S_IDLE);
    assign icache_req_valid_o  = w_miss_accept & rstn_i;
    assign buffer_miss_o       = w_miss_accept & rstn_i;
    assign icache_req_vaddr_o  = req_vaddr_i;
    assign icache_req_kill_o   = w_kill_out;
    assign icache_invalidate_o = req_inval_icache_i;

    assign resp_valid_o        = r_resp_valid;
    assign resp_data_o         = r_resp_data;
    assign resp_vaddr_o        = r_resp_vaddr;
    assign resp_page_fault_o   = r_resp_pf;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch_buf_if
// Description : Self-checking bench for icache_fetch_buf_if. Directed
//               scenarios plus a randomized run against a transaction-level
//               reference model (outstanding miss / killed flags, line copy).
//               A second instance built with 256-bit lines shares the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_buf_if;

    localparam int LB  = 128;
    localparam int VA  = 40;
    localparam int OFS = 4;

    logic            clk_i;
    logic            rstn_i;
    logic            req_valid_i;
    logic [VA-1:0]   req_vaddr_i;
    logic            req_kill_i;
    logic            req_flush_buf_i;
    logic            req_inval_icache_i;
    logic            icache_req_ready_i;
    logic            icache_resp_valid_i;
    logic [255:0]    rdata;
    logic            tlb_xcpt_i;

    logic            req_ready_o, icache_req_valid_o, icache_req_kill_o;
    logic            icache_invalidate_o, resp_valid_o, resp_page_fault_o, buffer_miss_o;
    logic [VA-1:0]   icache_req_vaddr_o, resp_vaddr_o;
    logic [31:0]     resp_data_o;

    logic            d2_ready, d2_icv, d2_kill, d2_inval, d2_rv, d2_pf, d2_miss;
    logic [VA-1:0]   d2_icva, d2_rva;
    logic [31:0]     d2_rdata;

    int vectors    = 0;
    int miscompares = 0;

    icache_fetch_buf_if #(.LINE_BITS(LB), .INSTR_BITS(32), .VADDR_BITS(VA)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_kill_i(req_kill_i),
        .req_flush_buf_i(req_flush_buf_i), .req_inval_icache_i(req_inval_icache_i),
        .req_ready_o(req_ready_o),
        .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
        .icache_req_vaddr_o(icache_req_vaddr_o), .icache_req_kill_o(icache_req_kill_o),
        .icache_invalidate_o(icache_invalidate_o),
        .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(rdata[LB-1:0]),
        .tlb_xcpt_i(tlb_xcpt_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_vaddr_o(resp_vaddr_o),
        .resp_page_fault_o(resp_page_fault_o), .buffer_miss_o(buffer_miss_o)
    );

    icache_fetch_buf_if #(.LINE_BITS(256), .INSTR_BITS(32), .VADDR_BITS(VA)) dut256 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_kill_i(req_kill_i),
        .req_flush_buf_i(req_flush_buf_i), .req_inval_icache_i(req_inval_icache_i),
        .req_ready_o(d2_ready),
        .icache_req_valid_o(d2_icv), .icache_req_ready_i(icache_req_ready_i),
        .icache_req_vaddr_o(d2_icva), .icache_req_kill_o(d2_kill),
        .icache_invalidate_o(d2_inval),
        .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(rdata),
        .tlb_xcpt_i(tlb_xcpt_i),
        .resp_valid_o(d2_rv), .resp_data_o(d2_rdata), .resp_vaddr_o(d2_rva),
        .resp_page_fault_o(d2_pf), .buffer_miss_o(d2_miss)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after that.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i         = 1'b0;
        req_vaddr_i         = '0;
        req_kill_i          = 1'b0;
        req_flush_buf_i     = 1'b0;
        req_inval_icache_i  = 1'b0;
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b0;
        rdata               = '0;
        tlb_xcpt_i          = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
    endtask

    task automatic issue_miss(input logic [VA-1:0] a);
        req_valid_i        = 1'b1;
        req_vaddr_i        = a;
        icache_req_ready_i = 1'b1;
        step();
        req_valid_i        = 1'b0;
        icache_req_ready_i = 1'b0;
    endtask

    // Word of a 128-bit line addressed by a, by plain arithmetic.
    function automatic logic [31:0] word_of(input logic [LB-1:0] line, input logic [VA-1:0] a);
        logic [LB-1:0] s;
        s = line >> (32 * (int'(a % 16) / 4));
        return s[31:0];
    endfunction

    task automatic test_reset();
        idle_inputs();
        rstn_i             = 1'b0;
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h1000;
        icache_req_ready_i = 1'b1;
        #1;
        vectors++; if (icache_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_icv: got %b want 0", icache_req_valid_o); end
        vectors++; if (buffer_miss_o !== 1'b0) begin miscompares++; $display("FAIL reset_miss: got %b want 0", buffer_miss_o); end
        vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rv: got %b want 0", resp_valid_o); end
        vectors++; if (resp_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", resp_data_o); end
        vectors++; if (resp_vaddr_o !== 40'h0) begin miscompares++; $display("FAIL reset_rvaddr: got %h want 0", resp_vaddr_o); end
        vectors++; if (resp_page_fault_o !== 1'b0) begin miscompares++; $display("FAIL reset_pf: got %b want 0", resp_page_fault_o); end
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
        apply_reset();
    endtask

    task automatic test_miss_hit();
        apply_reset();
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h1000;
        icache_req_ready_i = 1'b1;
        #1;
        vectors++; if (icache_req_valid_o !== 1'b1) begin miscompares++; $display("FAIL mh_icv: got %b want 1", icache_req_valid_o); end
        vectors++; if (buffer_miss_o !== 1'b1) begin miscompares++; $display("FAIL mh_miss: got %b want 1", buffer_miss_o); end
        step();
        req_valid_i         = 1'b0;
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b1;
        rdata = {128'hDEADBEEF_CCCC0000_BBBB0000_AAAA0000, 128'h44443333_22221111_66665555_88887777};
        #1;
        vectors++; if (req_ready_o !== 1'b0) begin miscompares++; $display("FAIL mh_busy: got %b want 0", req_ready_o); end
        step();
        icache_resp_valid_i = 1'b0;
        vectors++; if (resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL mh_rv: got %b want 1", resp_valid_o); end
        vectors++; if (resp_data_o !== 32'h88887777) begin miscompares++; $display("FAIL mh_rdata: got %h want 88887777", resp_data_o); end
        vectors++; if (resp_vaddr_o !== 40'h1000) begin miscompares++; $display("FAIL mh_rvaddr: got %h want 1000", resp_vaddr_o); end
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h100C;
        icache_req_ready_i = 1'b1;
        #1;
        vectors++; if (icache_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL hit_icv: got %b want 0", icache_req_valid_o); end
        vectors++; if (buffer_miss_o !== 1'b0) begin miscompares++; $display("FAIL hit_miss: got %b want 0", buffer_miss_o); end
        step();
        req_valid_i        = 1'b0;
        icache_req_ready_i = 1'b0;
        vectors++; if (resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL hit_rv: got %b want 1", resp_valid_o); end
        vectors++; if (resp_data_o !== 32'h44443333) begin miscompares++; $display("FAIL hit_rdata: got %h want 44443333", resp_data_o); end
        vectors++; if (resp_vaddr_o !== 40'h100C) begin miscompares++; $display("FAIL hit_rvaddr: got %h want 100c", resp_vaddr_o); end
        step();
        vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL hit_pulse: got %b want 0", resp_valid_o); end
        vectors++; if (resp_data_o !== 32'h44443333) begin miscompares++; $display("FAIL hit_hold: got %h want 44443333", resp_data_o); end
    endtask

    // Follows test_miss_hit: both instances hold line 0x1000.
    task automatic test_line256();
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h101C;
        icache_req_ready_i = 1'b0;
        #1;
        vectors++; if (d2_icv !== 1'b0) begin miscompares++; $display("FAIL l256_icv: got %b want 0", d2_icv); end
        step();
        req_valid_i = 1'b0;
        vectors++; if (d2_rv !== 1'b1) begin miscompares++; $display("FAIL l256_rv: got %b want 1", d2_rv); end
        vectors++; if (d2_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL l256_rdata: got %h want deadbeef", d2_rdata); end
        vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL l128_stall_rv: got %b want 0", resp_valid_o); end
    endtask

    task automatic test_kill();
        apply_reset();
        issue_miss(40'h1000);
        req_kill_i = 1'b1;
        #1;
        vectors++; if (icache_req_kill_o !== 1'b1) begin miscompares++; $display("FAIL kill_out: got %b want 1", icache_req_kill_o); end
        step();
        req_kill_i = 1'b0;
        #1;
        vectors++; if (req_ready_o !== 1'b0) begin miscompares++; $display("FAIL kill_drain: got %b want 0", req_ready_o); end
        icache_resp_valid_i = 1'b1;
        rdata = {8{32'h12345678}};
        step();
        icache_resp_valid_i = 1'b0;
        vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL kill_rv: got %b want 0", resp_valid_o); end
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL kill_idle: got %b want 1", req_ready_o); end
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h1004;
        icache_req_ready_i = 1'b1;
        #1;
        vectors++; if (buffer_miss_o !== 1'b1) begin miscompares++; $display("FAIL kill_nofill: got %b want 1", buffer_miss_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_xcpt();
        apply_reset();
        issue_miss(40'h3008);
        tlb_xcpt_i          = 1'b1;
        icache_resp_valid_i = 1'b1;
        rdata               = {8{32'hFFFFFFFF}};
        step();
        tlb_xcpt_i          = 1'b0;
        icache_resp_valid_i = 1'b0;
        vectors++; if (resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL xc_rv: got %b want 1", resp_valid_o); end
        vectors++; if (resp_page_fault_o !== 1'b1) begin miscompares++; $display("FAIL xc_pf: got %b want 1", resp_page_fault_o); end
        vectors++; if (resp_data_o !== 32'h0) begin miscompares++; $display("FAIL xc_data: got %h want 0", resp_data_o); end
        vectors++; if (resp_vaddr_o !== 40'h3008) begin miscompares++; $display("FAIL xc_vaddr: got %h want 3008", resp_vaddr_o); end
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h3008;
        icache_req_ready_i = 1'b1;
        #1;
        vectors++; if (buffer_miss_o !== 1'b1) begin miscompares++; $display("FAIL xc_nofill: got %b want 1", buffer_miss_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_flush();
        apply_reset();
        issue_miss(40'h2000);
        icache_resp_valid_i = 1'b1;
        rdata               = {8{32'hA5A5A5A5}};
        step();
        icache_resp_valid_i = 1'b0;
        req_flush_buf_i     = 1'b1;
        req_valid_i         = 1'b1;
        req_vaddr_i         = 40'h2004;
        icache_req_ready_i  = 1'b1;
        #1;
        vectors++; if (icache_req_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_icv: got %b want 0", icache_req_valid_o); end
        step();
        req_flush_buf_i = 1'b0;
        vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_rv: got %b want 0", resp_valid_o); end
        #1;
        vectors++; if (buffer_miss_o !== 1'b1) begin miscompares++; $display("FAIL flush_miss: got %b want 1", buffer_miss_o); end
        step();
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        req_valid_i        = 1'b1;
        req_vaddr_i        = 40'h5000;
        icache_req_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (icache_req_valid_o !== 1'b0 || buffer_miss_o !== 1'b0) begin
                miscompares++; $display("FAIL stall_c%0d: got icv=%b miss=%b want 0/0", c, icache_req_valid_o, buffer_miss_o);
            end
            step();
        end
        icache_req_ready_i = 1'b1;
        #1;
        vectors++; if (icache_req_valid_o !== 1'b1 || buffer_miss_o !== 1'b1) begin
            miscompares++; $display("FAIL stall_accept: got icv=%b miss=%b want 1/1", icache_req_valid_o, buffer_miss_o);
        end
        step();
        vectors++; if (buffer_miss_o !== 1'b0) begin miscompares++; $display("FAIL stall_single: got %b want 0", buffer_miss_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        issue_miss(40'h6000);
        rstn_i = 1'b0;
        #1;
        vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", req_ready_o); end
        step();
        rstn_i              = 1'b1;
        icache_resp_valid_i = 1'b1;
        step();
        icache_resp_valid_i = 1'b0;
        vectors++; if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_rv: got %b want 0", resp_valid_o); end
    endtask

    task automatic test_random(input int n);
        logic [VA-1:0] lines [4];
        logic [VA-1:0] a, m_paddr, m_btag;
        logic [LB-1:0] rd, m_bdata;
        bit m_bv, m_out, m_killed, hit, qual, e_icv, e_kill;
        bit v, k, fl, inv, icr, rv, xc;
        logic          exp_rv, exp_pf;
        logic [31:0]   exp_rd;
        logic [VA-1:0] exp_rva;
        lines[0] = 40'h1000; lines[1] = 40'h1010; lines[2] = 40'h2000; lines[3] = 40'hFF_FFFF_FFF0;
        apply_reset();
        m_bv = 0; m_out = 0; m_killed = 0; m_paddr = '0; m_btag = '0; m_bdata = '0;
        exp_rv = 0; exp_pf = 0; exp_rd = '0; exp_rva = '0;
        for (int i = 0; i < n; i++) begin
            vectors++; if (resp_valid_o !== exp_rv || resp_data_o !== exp_rd || resp_vaddr_o !== exp_rva || resp_page_fault_o !== exp_pf) begin
                miscompares++;
                $display("FAIL rnd_resp@%0d: got v=%b d=%h a=%h pf=%b want v=%b d=%h a=%h pf=%b", i,
                         resp_valid_o, resp_data_o, resp_vaddr_o, resp_page_fault_o, exp_rv, exp_rd, exp_rva, exp_pf);
            end
            v   = ($urandom % 10) < 7;
            k   = ($urandom % 10) == 0;
            fl  = ($urandom % 20) == 0;
            inv = ($urandom % 20) == 0;
            icr = ($urandom % 10) < 7;
            rv  = ($urandom % 10) < 4;
            xc  = ($urandom % 10) == 0;
            a   = lines[$urandom % 4] + 40'($urandom % 16);
            rd  = {$urandom, $urandom, $urandom, $urandom};
            req_valid_i = v; req_kill_i = k; req_flush_buf_i = fl; req_inval_icache_i = inv;
            icache_req_ready_i = icr; icache_resp_valid_i = rv; tlb_xcpt_i = xc;
            req_vaddr_i = a; rdata = {128'h0, rd};
            #1;
            qual   = v && !k && !fl;
            hit    = !m_out && qual && m_bv && ((a >> OFS) == m_btag);
            e_icv  = !m_out && qual && !hit && icr;
            e_kill = m_out && !m_killed && k && !rv && !xc;
            vectors++; if (req_ready_o !== !m_out || icache_req_valid_o !== e_icv || buffer_miss_o !== e_icv
                           || icache_req_kill_o !== e_kill || icache_invalidate_o !== inv || icache_req_vaddr_o !== a) begin
                miscompares++;
                $display("FAIL rnd_ctl@%0d: got rdy=%b icv=%b miss=%b kill=%b inv=%b va=%h want %b %b %b %b %b %h", i,
                         req_ready_o, icache_req_valid_o, buffer_miss_o, icache_req_kill_o, icache_invalidate_o,
                         icache_req_vaddr_o, !m_out, e_icv, e_icv, e_kill, inv, a);
            end
            exp_rv = 0;
            if (hit) begin
                exp_rv = 1; exp_rd = word_of(m_bdata, a); exp_rva = a; exp_pf = 0;
            end else if (e_icv) begin
                m_out = 1; m_killed = 0; m_paddr = a;
            end else if (m_out) begin
                if (xc || rv) begin
                    if (!m_killed && !k) begin
                        exp_rv = 1; exp_rva = m_paddr; exp_pf = xc;
                        exp_rd = xc ? 32'h0 : word_of(rd, m_paddr);
                    end
                    if (!m_killed && !xc) begin
                        m_bdata = rd; m_btag = m_paddr >> OFS; m_bv = 1;
                    end
                    m_out = 0;
                end else if (k) begin
                    m_killed = 1;
                end
            end
            if (fl || inv) m_bv = 0;
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rstn_i = 1'b0;
        test_reset();
        test_miss_hit();
        test_line256();
        test_kill();
        test_xcpt();
        test_flush();
        test_stall();
        test_reset_mid();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_fetch_buf_if.md
ICACHE_FETCH_BUF_IF -- requirements
Module: icache_fetch_buf_if

Interface
REQ-001 SHALL have parameter LINE_BITS, 128, icache line width in bits (power of two, 64..512).
REQ-002 SHALL have parameter INSTR_BITS, 32, width of one fetch word.
REQ-003 SHALL have parameter VADDR_BITS, 40, virtual address width.
REQ-004 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid_i in 1, req_vaddr_i in VADDR_BITS, req_kill_i in 1, req_flush_buf_i in 1, req_inval_icache_i in 1: the fetch-stage request.
REQ-007 SHALL have port req_ready_o  out  1  ready to accept a fetch request.
REQ-008 SHALL have ports icache_req_valid_o out 1, icache_req_ready_i in 1, icache_req_vaddr_o out VADDR_BITS, icache_req_kill_o out 1, icache_invalidate_o out 1.
REQ-009 SHALL have ports icache_resp_valid_i in 1, icache_resp_data_i in LINE_BITS, tlb_xcpt_i in 1 (instruction page fault).
REQ-010 SHALL have ports resp_valid_o out 1, resp_data_o out INSTR_BITS, resp_vaddr_o out VADDR_BITS, resp_page_fault_o out 1.
REQ-011 SHALL have port buffer_miss_o  out  1  one-cycle pulse per line-buffer miss (PMU).

Function
REQ-012 SHALL hold a single line buffer: LINE_BITS of data, tag = vaddr[VADDR_BITS-1:OFS], valid bit; OFS = log2(LINE_BITS/8).
REQ-013 SHALL select the word at vaddr[OFS-1:log2(INSTR_BITS/8)], word 0 at data LSBs.
REQ-014 SHALL implement FSM IDLE, WAIT_RESP, DRAIN; req_ready_o = 1 only in IDLE.
REQ-015 IDLE, req_valid_i & ~req_kill_i & ~req_flush_buf_i & buffer valid & tag match: hit; no icache request; resp_valid_o = 1 in the next cycle with the selected word, resp_vaddr_o = request vaddr, resp_page_fault_o = 0.
REQ-016 IDLE, same qualifiers but miss: icache_req_valid_o = icache_req_ready_i combinationally, icache_req_vaddr_o = req_vaddr_i.
REQ-017 On miss with icache_req_ready_i = 1: latch vaddr, pulse buffer_miss_o in the same cycle, go to WAIT_RESP.
REQ-018 On miss with icache_req_ready_i = 0: stay IDLE, no pulse; the request is re-evaluated every cycle.
REQ-019 WAIT_RESP, icache_resp_valid_i & ~tlb_xcpt_i: fill buffer (data, latched tag, valid = 1); resp_valid_o = 1 in the next cycle with the selected word; go to IDLE.
REQ-020 WAIT_RESP, tlb_xcpt_i (priority over icache_resp_valid_i): no fill; next cycle resp_valid_o = 1, resp_data_o = 0, resp_page_fault_o = 1; go to IDLE.
REQ-021 WAIT_RESP, req_kill_i with neither response nor xcpt: icache_req_kill_o = 1 that cycle; go to DRAIN.
REQ-022 WAIT_RESP, req_kill_i in the same cycle as a response or xcpt: drop the response (no resp_valid_o); the buffer is still filled if ~tlb_xcpt_i; go to IDLE.
REQ-023 DRAIN: stay until icache_resp_valid_i or tlb_xcpt_i; discard it (no fill, no resp_valid_o); go to IDLE.
REQ-024 req_flush_buf_i in any state: clear buffer valid; in IDLE, no request issued and no response produced.
REQ-025 icache_invalidate_o = req_inval_icache_i combinationally; it also clears buffer valid, including an in-flight fill in the same cycle.
REQ-026 icache_resp_valid_i in IDLE: ignored.
REQ-027 resp_valid_o is a single-cycle pulse per accepted request; there is no backpressure on the response.
REQ-028 resp_data_o, resp_vaddr_o, resp_page_fault_o are registered and hold their last value while resp_valid_o = 0.

Reset
REQ-029 While rstn_i = 0: state IDLE, buffer valid = 0, latched vaddr = 0, resp_valid_o = 0, resp_data_o = 0, resp_vaddr_o = 0, resp_page_fault_o = 0, buffer_miss_o = 0, icache_req_valid_o = 0.
REQ-030 Reset asserted mid-request (WAIT_RESP/DRAIN): return to IDLE; a later icache response is ignored per REQ-026.

Verification
REQ-031 Reset, req 0x1000, icache ready, resp data 0x44443333_22221111_...: miss pulse, resp_valid_o next cycle with data of word 0 -> then req 0x100C hits: no icache_req_valid_o, resp 0x44443333 one cycle later.
REQ-032 Miss in flight, req_kill_i in WAIT_RESP -> icache_req_kill_o = 1; the later response produces no resp_valid_o and no fill; next req to the same line misses.
REQ-033 Miss with tlb_xcpt_i -> resp_valid_o = 1, resp_page_fault_o = 1, data 0; buffer stays invalid.
REQ-034 Buffer valid for 0x2000, req_flush_buf_i pulse, then req 0x2004 -> miss, buffer_miss_o = 1.
REQ-035 icache_req_ready_i = 0 for 3 cycles on a miss -> icache_req_valid_o = 0 for 3 cycles, single buffer_miss_o pulse on the accept cycle.
REQ-036 LINE_BITS = 256 build: req 0x101C after fill of 0x1000 -> hit, word 7 (bits 255:224) returned.
